// File: rtl/stream_demux_router.sv
// Packet-atomic demultiplexer: routes a merged id/qos/last stream to STREAM_COUNT
// one-deep registered output slices, discarding and counting packets with an out-of-range id.
module stream_demux_router #(
    parameter int T_DATA_WIDTH   = 8,
    parameter int T_QOS__WIDTH   = 4,
    parameter int STREAM_COUNT   = 2,
    parameter int T_ID___WIDTH   = $clog2(STREAM_COUNT),
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_n,
    input  logic [T_DATA_WIDTH-1:0]   s_data_i,
    input  logic [T_QOS__WIDTH-1:0]   s_qos_i,
    input  logic [T_ID___WIDTH-1:0]   s_id_i,
    input  logic                      s_last_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    output logic [T_DATA_WIDTH-1:0]   m_data_o  [STREAM_COUNT],
    output logic [T_QOS__WIDTH-1:0]   m_qos_o   [STREAM_COUNT],
    output logic [STREAM_COUNT-1:0]   m_last_o,
    output logic [STREAM_COUNT-1:0]   m_valid_o,
    input  logic [STREAM_COUNT-1:0]   m_ready_i,
    output logic                      drop_pkt_o,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PKT,
        ST_DROP
    } state_t;

    state_t                  state_q, state_d;
    logic [T_ID___WIDTH-1:0] lock_id_q, lock_id_d;
    logic [T_ID___WIDTH-1:0] route;
    logic                    id_valid;
    logic                    discard;
    logic                    route_busy;
    logic                    accept;
    logic                    drop_evt;
    logic [STREAM_COUNT-1:0] load;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        lock_id_d  = lock_id_q;
        drop_evt   = 1'b0;
        route_busy = 1'b0;
        load       = '0;

        id_valid = int'(s_id_i) < STREAM_COUNT;
        route    = (state_q == ST_PKT) ? lock_id_q : s_id_i;
        discard  = (state_q == ST_DROP) || ((state_q == ST_IDLE) && !id_valid);

        // Only the routed slice can stall the input; idle outputs drain on their own.
        for (int i = 0; i < STREAM_COUNT; i++) begin
            if (route == T_ID___WIDTH'(i)) begin
                route_busy = m_valid_o[i] & ~m_ready_i[i];
            end
        end

        s_ready_o = discard | ~route_busy;
        accept    = s_valid_i & s_ready_o;

        for (int i = 0; i < STREAM_COUNT; i++) begin
            load[i] = accept & ~discard & (route == T_ID___WIDTH'(i));
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (id_valid) begin
                        if (!s_last_i) begin
                            state_d   = ST_PKT;
                            lock_id_d = s_id_i;
                        end
                    end else if (s_last_i) begin
                        drop_evt = 1'b1;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_PKT: begin
                if (accept && s_last_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (accept && s_last_i) begin
                    state_d  = ST_IDLE;
                    drop_evt = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
        end
    end

    // NOTE: slice payloads are reset as well, so a reset flushes everything in flight to a known zero.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_o <= '0;
            m_last_o  <= '0;
            for (int i = 0; i < STREAM_COUNT; i++) begin
                m_data_o[i] <= '0;
                m_qos_o[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < STREAM_COUNT; i++) begin
                if (load[i]) begin
                    m_valid_o[i] <= 1'b1;
                    m_last_o[i]  <= s_last_i;
                    m_data_o[i]  <= s_data_i;
                    m_qos_o[i]   <= s_qos_i;
                end else if (m_ready_i[i]) begin
                    m_valid_o[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            drop_pkt_o <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            drop_pkt_o <= drop_evt;
            if (drop_evt && (drop_cnt_o != '1)) begin
                drop_cnt_o <= drop_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_demux_router.sv
// Randomized and directed bench for stream_demux_router against a queue-based
// packet model: per-output pending beats, packet mode, and drop counting.
module tb_stream_demux_router;

    localparam int SC = 3;
    localparam int DW = 8;
    localparam int QW = 4;
    localparam int IW = 2;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    localparam int M_IDLE = 0;
    localparam int M_PKT  = 1;
    localparam int M_DROP = 2;

    logic          clk_i = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s_data;
    logic [QW-1:0] s_qos;
    logic [IW-1:0] s_id;
    logic          s_last;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] m_data [SC];
    logic [QW-1:0] m_qos  [SC];
    logic [SC-1:0] m_last;
    logic [SC-1:0] m_valid;
    logic [SC-1:0] m_ready;
    logic          drop_pkt;
    logic [CW-1:0] drop_cnt;

    always #5 clk_i = ~clk_i;

    stream_demux_router #(
        .T_DATA_WIDTH  (DW),
        .T_QOS__WIDTH  (QW),
        .STREAM_COUNT  (SC),
        .T_ID___WIDTH  (IW),
        .DROP_CNT_WIDTH(CW)
    ) dut (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .s_data_i  (s_data),
        .s_qos_i   (s_qos),
        .s_id_i    (s_id),
        .s_last_i  (s_last),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .m_data_o  (m_data),
        .m_qos_o   (m_qos),
        .m_last_o  (m_last),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .drop_pkt_o(drop_pkt),
        .drop_cnt_o(drop_cnt)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [QW-1:0] qos;
        logic          last;
    } beat_t;

    // Reference model: beats accepted but not yet taken by each output, in order.
    beat_t exp_q [SC][$];
    int    mode;
    int    dest;
    int    exp_cnt;
    logic  exp_pulse;

    int n_checks = 0;
    int n_pass   = 0;
    int seen_xfer [SC];
    int seen_drops;

    task automatic model_reset();
        for (int o = 0; o < SC; o++) exp_q[o].delete();
        mode      = M_IDLE;
        dest      = 0;
        exp_cnt   = 0;
        exp_pulse = 1'b0;
    endtask

    task automatic clear_seen();
        for (int o = 0; o < SC; o++) seen_xfer[o] = 0;
        seen_drops = 0;
    endtask

    // One clock cycle: drive, compare DUT against the model, then advance the model at the edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [QW-1:0] q,
                         input logic [IW-1:0] id, input logic l, input logic [SC-1:0] mr,
                         output logic acc);
        logic          discard;
        logic          exp_ready;
        logic          drop_evt;
        logic [SC-1:0] exp_v;
        int            route;
        beat_t         got;

        s_valid = v;
        s_data  = d;
        s_qos   = q;
        s_id    = id;
        s_last  = l;
        m_ready = mr;
        #3;

        discard = (mode == M_DROP) || (mode == M_IDLE && int'(id) >= SC);
        route   = (mode == M_PKT) ? dest : int'(id);
        if (discard) exp_ready = 1'b1;
        else         exp_ready = (exp_q[route].size() == 0) || mr[route];

        n_checks++;
        if (s_ready !== exp_ready)
            $display("FAIL s_ready @%0t: got %b expected %b", $time, s_ready, exp_ready);
        else n_pass++;

        for (int o = 0; o < SC; o++) exp_v[o] = (exp_q[o].size() != 0);
        n_checks++;
        if (m_valid !== exp_v)
            $display("FAIL m_valid @%0t: got %b expected %b", $time, m_valid, exp_v);
        else n_pass++;

        for (int o = 0; o < SC; o++) begin
            if (exp_v[o]) begin
                got = {m_data[o], m_qos[o], m_last[o]};
                n_checks++;
                if (got !== exp_q[o][0])
                    $display("FAIL payload[%0d] @%0t: got %h expected %h", o, $time, got, exp_q[o][0]);
                else n_pass++;
            end
        end

        n_checks++;
        if (drop_pkt !== exp_pulse)
            $display("FAIL drop_pkt @%0t: got %b expected %b", $time, drop_pkt, exp_pulse);
        else n_pass++;

        n_checks++;
        if (drop_cnt !== CW'(exp_cnt))
            $display("FAIL drop_cnt @%0t: got %0d expected %0d", $time, drop_cnt, exp_cnt);
        else n_pass++;

        for (int o = 0; o < SC; o++) if (m_valid[o] && mr[o]) seen_xfer[o]++;
        if (drop_pkt) seen_drops++;

        @(posedge clk_i);
        acc      = v && exp_ready;
        drop_evt = 1'b0;
        for (int o = 0; o < SC; o++)
            if (exp_q[o].size() != 0 && mr[o]) void'(exp_q[o].pop_front());
        if (acc) begin
            if (discard) begin
                if (l) begin
                    mode     = M_IDLE;
                    drop_evt = 1'b1;
                end else begin
                    mode = M_DROP;
                end
            end else begin
                exp_q[route].push_back({d, q, l});
                if (l) begin
                    mode = M_IDLE;
                end else begin
                    dest = route;
                    mode = M_PKT;
                end
            end
        end
        exp_pulse = drop_evt;
        if (drop_evt && exp_cnt < CNT_MAX) exp_cnt++;
        #1;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, 1'b0, '1, acc);
    endtask

    // Holds one beat on the input until the model says it was accepted.
    task automatic send_beat(input logic [DW-1:0] d, input logic [QW-1:0] q,
                             input logic [IW-1:0] id, input logic l, input logic [SC-1:0] mr);
        logic acc;
        int   tries;
        tries = 0;
        do begin
            cycle(1'b1, d, q, id, l, mr, acc);
            tries++;
        end while (!acc && tries < 50);
        if (!acc) begin
            n_checks++;
            $display("FAIL send_beat timeout @%0t: beat %h never accepted", $time, d);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (m_valid !== '0 || m_last !== '0) $display("FAIL reset_valid: got %b/%b expected 0", m_valid, m_last);
        else n_pass++;
        for (int o = 0; o < SC; o++) begin
            n_checks++;
            if (m_data[o] !== '0 || m_qos[o] !== '0)
                $display("FAIL reset_payload[%0d]: got %h/%h expected 0", o, m_data[o], m_qos[o]);
            else n_pass++;
        end
        n_checks++;
        if (drop_pkt !== 1'b0 || drop_cnt !== '0)
            $display("FAIL reset_drop: got %b/%0d expected 0/0", drop_pkt, drop_cnt);
        else n_pass++;
        n_checks++;
        if (s_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", s_ready);
        else n_pass++;
        model_reset();
        rst_n = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_single_packet();
        clear_seen();
        for (int b = 0; b < 4; b++) send_beat(DW'(8'h10 + b), 4'd5, 2'd1, b == 3, '1);
        idle(2);
        n_checks++;
        if (seen_xfer[1] != 4 || seen_xfer[0] != 0 || seen_xfer[2] != 0)
            $display("FAIL single_packet: got %0d/%0d/%0d expected 0/4/0", seen_xfer[0], seen_xfer[1], seen_xfer[2]);
        else n_pass++;
    endtask

    task automatic test_id_locked();
        clear_seen();
        send_beat(8'h20, 4'd3, 2'd2, 1'b0, '1);
        send_beat(8'h21, 4'd3, 2'd0, 1'b0, '1);
        send_beat(8'h22, 4'd3, 2'd0, 1'b1, '1);
        idle(2);
        n_checks++;
        if (seen_xfer[2] != 3 || seen_xfer[0] != 0)
            $display("FAIL id_locked: got out2=%0d out0=%0d expected 3/0", seen_xfer[2], seen_xfer[0]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic acc;
        clear_seen();
        cycle(1'b1, 8'hA0, 4'd1, 2'd0, 1'b0, 3'b110, acc);
        cycle(1'b1, 8'hA1, 4'd1, 2'd0, 1'b1, 3'b110, acc);
        cycle(1'b1, 8'hA1, 4'd1, 2'd0, 1'b1, 3'b110, acc);
        n_checks++;
        if (seen_xfer[0] != 0 || s_ready !== 1'b0)
            $display("FAIL backpressure_stall: got xfer=%0d ready=%b expected 0/0", seen_xfer[0], s_ready);
        else n_pass++;
        cycle(1'b1, 8'hA1, 4'd1, 2'd0, 1'b1, 3'b111, acc);
        idle(2);
        n_checks++;
        if (seen_xfer[0] != 2) $display("FAIL backpressure_release: got %0d beats expected 2", seen_xfer[0]);
        else n_pass++;
    endtask

    task automatic test_drop();
        clear_seen();
        send_beat(8'h30, 4'd2, 2'd3, 1'b0, '1);
        send_beat(8'h31, 4'd2, 2'd1, 1'b0, '1);
        send_beat(8'h32, 4'd2, 2'd0, 1'b1, '1);
        send_beat(8'h40, 4'd6, 2'd0, 1'b1, '1);
        idle(2);
        n_checks++;
        if (drop_cnt !== CW'(1) || seen_drops != 1)
            $display("FAIL drop_count: got cnt=%0d pulses=%0d expected 1/1", drop_cnt, seen_drops);
        else n_pass++;
        n_checks++;
        if (seen_xfer[0] != 1 || seen_xfer[1] != 0 || seen_xfer[2] != 0)
            $display("FAIL drop_routing: got %0d/%0d/%0d expected 1/0/0", seen_xfer[0], seen_xfer[1], seen_xfer[2]);
        else n_pass++;
    endtask

    task automatic test_drop_saturate();
        clear_seen();
        for (int i = 0; i < 20; i++) send_beat(DW'(i), 4'd0, 2'd3, 1'b1, '1);
        idle(2);
        n_checks++;
        if (drop_cnt !== CW'(CNT_MAX) || seen_drops != 20)
            $display("FAIL drop_saturate: got cnt=%0d pulses=%0d expected %0d/20", drop_cnt, seen_drops, CNT_MAX);
        else n_pass++;
    endtask

    task automatic test_random();
        logic acc;
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), DW'($urandom), QW'($urandom), IW'($urandom_range(0, 3)),
                  1'($urandom_range(0, 2) == 0),
                  {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)},
                  acc);
        end
        send_beat(8'hEE, 4'd0, 2'd0, 1'b1, '1);
        idle(3);
        n_checks++;
        if (m_valid !== '0 || mode != M_IDLE)
            $display("FAIL random_drain: got m_valid=%b mode=%0d expected 0/idle", m_valid, mode);
        else n_pass++;
    endtask

    task automatic test_reset_mid_packet();
        logic acc;
        send_beat(8'h55, 4'd2, 2'd1, 1'b0, 3'b101);
        cycle(1'b1, 8'h56, 4'd2, 2'd1, 1'b0, 3'b101, acc);
        n_checks++;
        if (m_valid[1] !== 1'b1) $display("FAIL pre_reset_hold: got %b expected 1", m_valid[1]);
        else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (m_valid !== '0 || drop_cnt !== '0 || drop_pkt !== 1'b0)
            $display("FAIL async_reset: got valid=%b cnt=%0d pulse=%b expected 0", m_valid, drop_cnt, drop_pkt);
        else n_pass++;
        s_valid = 1'b0;
        model_reset();
        @(posedge clk_i);
        #2 rst_n = 1'b1;
        @(posedge clk_i);
        #1;
        clear_seen();
        send_beat(8'h77, 4'd3, 2'd0, 1'b1, '1);
        idle(2);
        n_checks++;
        if (seen_xfer[0] != 1 || seen_xfer[1] != 0)
            $display("FAIL post_reset_route: got out0=%0d out1=%0d expected 1/0", seen_xfer[0], seen_xfer[1]);
        else n_pass++;
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_qos   = '0;
        s_id    = '0;
        s_last  = 1'b0;
        m_ready = '1;
        #12;
        test_reset();
        test_single_packet();
        test_id_locked();
        test_back_to_back();
        test_drop();
        test_drop_saturate();
        test_random();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/stream_demux_router.md
Name: stream_demux_router

Overview:
- Egress counterpart of the QoS stream arbiter: takes one merged stream tagged with id/qos/last and routes each packet to one of STREAM_COUNT output streams selected by the id.
- Packet-atomic: the id on a packet's first beat selects the destination, and that destination holds until the last beat.
- Each output has a one-deep registered slice (latency 1, full throughput).
- Packets with an out-of-range id are discarded and counted.

Parameters:
T_DATA_WIDTH, 8, data width per beat
T_QOS__WIDTH, 4, qos width, passed through unchanged
STREAM_COUNT, 2, number of output streams (>=2)
T_ID___WIDTH, $clog2(STREAM_COUNT), id width
DROP_CNT_WIDTH, 16, width of the drop counter

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
s_data_i  input  T_DATA_WIDTH  input beat data
s_qos_i  input  T_QOS__WIDTH  input beat qos
s_id_i  input  T_ID___WIDTH  destination id, sampled on first beat of packet
s_last_i  input  1  last beat of packet
s_valid_i  input  1  input valid
s_ready_o  output  1  input ready
m_data_o  output  [T_DATA_WIDTH-1:0] x STREAM_COUNT (unpacked)  per-output data
m_qos_o  output  [T_QOS__WIDTH-1:0] x STREAM_COUNT (unpacked)  per-output qos
m_last_o  output  STREAM_COUNT  per-output last
m_valid_o  output  STREAM_COUNT  per-output valid
m_ready_i  input  STREAM_COUNT  per-output ready
drop_pkt_o  output  1  one-cycle pulse when an invalid-id packet completes discard
drop_cnt_o  output  DROP_CNT_WIDTH  saturating count of dropped packets

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; m_valid_o=0; m_data_o/m_qos_o/m_last_o=0; drop_pkt_o=0; drop_cnt_o=0; lock_id=0. Reset mid-packet discards everything in flight, including the output slices. After release the first accepted beat is a packet start.
- Handshakes: beat accepted when s_valid_i & s_ready_o. Output i transfers when m_valid_o[i] & m_ready_i[i]. Once m_valid_o[i] is asserted, it and its payload stay stable until the transfer.
- FSM states:
  - IDLE: no packet open. route = s_id_i.
  - PKT: route = lock_id; s_id_i is ignored.
  - DROP: discarding the rest of an invalid packet.
- Transitions from IDLE on an accepted beat:
  - s_id_i < STREAM_COUNT and s_last_i=0 -> PKT; lock_id <= s_id_i.
  - s_id_i < STREAM_COUNT and s_last_i=1 -> stay IDLE (single-beat packet).
  - s_id_i >= STREAM_COUNT and s_last_i=0 -> DROP.
  - s_id_i >= STREAM_COUNT and s_last_i=1 -> stay IDLE; drop event.
- PKT: accepted beat with s_last_i=1 -> IDLE.
- DROP: accepted beat with s_last_i=1 -> IDLE; drop event.
- s_ready_o:
  - DROP, or IDLE with invalid s_id_i: s_ready_o = 1.
  - Otherwise: s_ready_o = !m_valid_o[route] | m_ready_i[route].
  - s_ready_o is combinational from route, m_valid_o and m_ready_i; it does not depend on s_valid_i.
- Slice i, per cycle:
  - Load beat (data/qos/last, valid=1) when a beat is accepted with route=i. This includes a same-cycle drain plus load, so back-to-back beats are sustained at one beat per cycle.
  - Else clear valid when the output transfers.
  - Else hold.
  - Non-routed slices are unaffected, so they drain independently.
- Latency: accepted beat appears on its output the next cycle.
- Drop event: drop_pkt_o=1 for exactly the following cycle. drop_cnt_o increments by 1 and saturates at all-ones with no wrap.
- Beat order within an output is preserved. Packets to different outputs never interleave on the input (input is packet-serial). A blocked output stalls the input only while that output is the route.
- With STREAM_COUNT a power of two, no invalid ids exist and the drop logic is unreachable. It must still compile.

Test Plan:
- STREAM_COUNT=3, all m_ready_i=1. Send 4-beat packet id=1, data 0x10..0x13, qos=5 -> m_valid_o=3'b010 for 4 consecutive cycles, each starting 1 cycle after acceptance; data 0x10..0x13, qos=5, m_last_o[1]=1 on 0x13 only; s_ready_o stays 1.
- Packet id=2 whose beats 2-3 carry s_id_i=0 -> all 3 beats appear on output 2 only; output 0 never valid.
- m_ready_i[0]=0, send 2-beat packet id=0 -> first beat held on m_data_o[0], s_ready_o=0 on second beat. Raise m_ready_i[0] -> second beat accepted that cycle and appears next cycle; no beat lost or duplicated.
- Packet id=3 (invalid, 3 beats) followed by 1-beat packet id=0 -> s_ready_o=1 throughout; no m_valid_o for the id=3 beats; drop_pkt_o pulses once; drop_cnt_o=1; id=0 beat delivered normally.
- Force 2^16+2 invalid single-beat packets (or DROP_CNT_WIDTH=2 with 5 drops) -> drop_cnt_o saturates at all-ones and does not wrap.
- Assert rst_n=0 mid-packet with m_valid_o[1]=1 held -> m_valid_o=0 and drop_cnt_o=0 immediately (async). After release, a new packet id=0 routes to output 0 (lock not retained).
